win_tracker: RTL and testbench

WIN_TRACKER -- requirements
Module: win_tracker

---
 rtl/win_tracker.sv | 162 ++++++++++++++++
 tb/tb_win_tracker.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_tracker.sv
// Round/win sequencer for the ball game: confirms wins, holds the banner, counts to game over.
// Optional PLAY-state timeout is built only when WIN_TRACKER_TIMEOUT_EN is defined.
module win_tracker #(
  parameter int CONFIRM_FRAMES = 2,
  parameter int HOLD_FRAMES    = 120,
  parameter int MAX_WINS       = 9,
  parameter int TIMEOUT_FRAMES = 900
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       W,
  input  logic       Start,
  output logic       play_en,
  output logic       round_reset,
  output logic [3:0] win_count,
  output logic       game_over,
  output logic       win_flash,
  output logic       timed_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    WIN_HOLD = 2'd2,
    OVER     = 2'd3
  } state_t;

  localparam logic [3:0] CONF_LAST = 4'(CONFIRM_FRAMES - 1);
  localparam logic [9:0] HOLD_LAST = 10'(HOLD_FRAMES - 1);
  localparam logic [3:0] WIN_MAX   = 4'(MAX_WINS);

  state_t     state_r, state_s;
  logic [3:0] confirm_r, confirm_s;
  logic [9:0] hold_r, hold_s;
  logic [3:0] win_count_r, win_count_s;
  logic       round_reset_r, round_reset_s;
  logic       play_en_r, game_over_r, win_flash_r;

`ifdef WIN_TRACKER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_FRAMES > 2) ? $clog2(TIMEOUT_FRAMES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_FRAMES - 1);
  logic [TW-1:0] timer_r, timer_s;
  logic          timed_out_r, timed_out_s;
`endif

  // Next-state, counter and pulse decode; a win beats a timeout on the same edge.
  always_comb begin
    state_s       = state_r;
    confirm_s     = confirm_r;
    hold_s        = hold_r;
    win_count_s   = win_count_r;
    round_reset_s = 1'b0;
`ifdef WIN_TRACKER_TIMEOUT_EN
    timer_s       = timer_r;
    timed_out_s   = timed_out_r;
`endif
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_s   = PLAY;
          confirm_s = 4'd0;
`ifdef WIN_TRACKER_TIMEOUT_EN
          timer_s     = '0;
          timed_out_s = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      PLAY: begin
        if (W && (confirm_r == CONF_LAST)) begin
          state_s     = WIN_HOLD;
          confirm_s   = 4'd0;
          hold_s      = 10'd0;
          win_count_s = (win_count_r < WIN_MAX) ? (win_count_r + 4'd1) : win_count_r;
        end
`ifdef WIN_TRACKER_TIMEOUT_EN
        else if (timer_r == TO_LAST) begin
          state_s       = IDLE;
          confirm_s     = 4'd0;
          timed_out_s   = 1'b1;
          round_reset_s = 1'b1;
        end
`endif
        else begin
          confirm_s = W ? (confirm_r + 4'd1) : 4'd0;
`ifdef WIN_TRACKER_TIMEOUT_EN
          timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
`endif
        end
      end
      WIN_HOLD: begin
        if (hold_r == HOLD_LAST) begin
          hold_s        = 10'd0;
          round_reset_s = 1'b1;
          state_s       = (win_count_r == WIN_MAX) ? OVER : IDLE;
        end else begin
          hold_s = hold_r + 10'd1;
        end
      end
      OVER: begin
        if (Start) begin
          state_s       = IDLE;
          win_count_s   = 4'd0;
          round_reset_s = 1'b1;
        end else begin
          state_s = OVER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs decode the next state so they move with it.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_r       <= IDLE;
      confirm_r     <= 4'd0;
      hold_r        <= 10'd0;
      win_count_r   <= 4'd0;
      round_reset_r <= 1'b0;
      play_en_r     <= 1'b0;
      game_over_r   <= 1'b0;
      win_flash_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      confirm_r     <= confirm_s;
      hold_r        <= hold_s;
      win_count_r   <= win_count_s;
      round_reset_r <= round_reset_s;
      play_en_r     <= (state_s == PLAY);
      game_over_r   <= (state_s == OVER);
      win_flash_r   <= (state_s == WIN_HOLD);
    end
  end

`ifdef WIN_TRACKER_TIMEOUT_EN
  // PLAY frame timer and sticky timeout flag.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      timer_r     <= '0;
      timed_out_r <= 1'b0;
    end else begin
      timer_r     <= timer_s;
      timed_out_r <= timed_out_s;
    end
  end

  assign timed_out = timed_out_r;
`else
  assign timed_out = 1'b0;
`endif

  assign play_en     = play_en_r;
  assign round_reset = round_reset_r;
  assign win_count   = win_count_r;
  assign game_over   = game_over_r;
  assign win_flash   = win_flash_r;

endmodule

// File: tb/tb_win_tracker.sv
// Self-checking bench for win_tracker: directed scenarios plus random W/Start against a frame-level model.
module tb_win_tracker;

  localparam int CONF = 2;
  localparam int HOLD = 120;
  localparam int MAXW = 2;
  localparam int TO   = 10;
`ifdef WIN_TRACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic       W = 1'b0;
  logic       Start = 1'b0;
  logic       play_en, round_reset, game_over, win_flash, timed_out;
  logic [3:0] win_count;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  // Model: mode 0=idle 1=play 2=hold 3=over, plus plain integer counters.
  int m_mode, m_run, m_hold, m_frames, m_wins;
  bit m_to, m_rr;

  win_tracker #(
    .CONFIRM_FRAMES(CONF),
    .HOLD_FRAMES   (HOLD),
    .MAX_WINS      (MAXW),
    .TIMEOUT_FRAMES(TO)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .W          (W),
    .Start      (Start),
    .play_en    (play_en),
    .round_reset(round_reset),
    .win_count  (win_count),
    .game_over  (game_over),
    .win_flash  (win_flash),
    .timed_out  (timed_out)
  );

  always #5 frame_clk = ~frame_clk;

  assign outs = {play_en, round_reset, win_count, game_over, win_flash, timed_out};

  function automatic logic [8:0] vec(input bit p, input bit rr, input int c,
                                     input bit o, input bit f, input bit t);
    return {p, rr, 4'(c), o, f, t};
  endfunction

  function automatic logic [8:0] model_vec();
    return vec(m_mode == 1, m_rr, m_wins, m_mode == 3, m_mode == 2, m_to);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_hold = 0; m_frames = 0; m_wins = 0; m_to = 1'b0; m_rr = 1'b0;
  endtask

  task automatic model_step(input bit w, input bit s);
    m_rr = 1'b0;
    case (m_mode)
      0: if (s) begin m_mode = 1; m_to = 1'b0; m_run = 0; m_frames = 0; end
      1: begin
        m_run = w ? m_run + 1 : 0;
        if (m_run == CONF) begin
          m_wins = (m_wins < MAXW) ? m_wins + 1 : m_wins;
          m_mode = 2;
          m_hold = 0;
        end else if (TO_EN && m_frames == TO - 1) begin
          m_to = 1'b1; m_rr = 1'b1; m_mode = 0;
        end else begin
          m_frames++;
        end
      end
      2: if (m_hold == HOLD - 1) begin
           m_rr = 1'b1;
           m_mode = (m_wins == MAXW) ? 3 : 0;
         end else begin
           m_hold++;
         end
      3: if (s) begin m_wins = 0; m_rr = 1'b1; m_mode = 0; end
      default: m_mode = 0;
    endcase
  endtask

  task automatic cycle(input bit w, input bit s);
    W = w;
    Start = s;
    @(posedge frame_clk);
    model_step(w, s);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0; W = 1'b0; Start = 1'b0;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; W = 1'b1; Start = 1'b1;
    repeat (3) @(posedge frame_clk);
    #1;
    checks++;
    if (outs !== 9'd0) begin errors++; $display("FAIL reset_values got %b want %b", outs, 9'd0); end
    model_reset();
    Start = 1'b0;
    Reset = 1'b1;
    cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL first_cycle_idle got %b want %b", outs, vec(0, 0, 0, 0, 0, 0)); end
    cycle(1'b0, 1'b1);
    checks++;
    if (outs !== vec(1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL start_to_play got %b want %b", outs, vec(1, 0, 0, 0, 0, 0)); end
  endtask

  task automatic test_glitch();
    logic [3:0] pat;
    pat = 4'b0101;
    for (int i = 3; i >= 0; i--) begin
      cycle(pat[i], 1'b0);
      checks++;
      if (outs !== vec(1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL glitch_%0d got %b want %b", i, outs, vec(1, 0, 0, 0, 0, 0)); end
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (outs !== vec(1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL start_ignored_play got %b want %b", outs, vec(1, 0, 0, 0, 0, 0)); end
  endtask

  task automatic test_basic_win();
    int bad;
    apply_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL win_confirm1 got %b want %b", outs, vec(1, 0, 0, 0, 0, 0)); end
    cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(0, 0, 1, 0, 1, 0)) begin errors++; $display("FAIL win_enter_hold got %b want %b", outs, vec(0, 0, 1, 0, 1, 0)); end
    bad = 0;
    for (int i = 0; i < HOLD - 1; i++) begin
      cycle(1'b1, 1'b1);
      if (outs !== vec(0, 0, 1, 0, 1, 0)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL win_hold_steady got %0d bad cycles want 0", bad); end
    cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(0, 1, 1, 0, 0, 0)) begin errors++; $display("FAIL win_round_reset got %b want %b", outs, vec(0, 1, 1, 0, 0, 0)); end
    cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(0, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL win_idle_after got %b want %b", outs, vec(0, 0, 1, 0, 0, 0)); end
  endtask

  task automatic test_w_held_retrigger();
    cycle(1'b1, 1'b1);
    checks++;
    if (outs !== vec(1, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL held_w_entry got %b want %b", outs, vec(1, 0, 1, 0, 0, 0)); end
    cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(1, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL held_w_no_retrigger got %b want %b", outs, vec(1, 0, 1, 0, 0, 0)); end
    cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(0, 0, 2, 0, 1, 0)) begin errors++; $display("FAIL second_win got %b want %b", outs, vec(0, 0, 2, 0, 1, 0)); end
  endtask

  task automatic test_game_over();
    repeat (HOLD - 1) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if (outs !== vec(0, 1, 2, 1, 0, 0)) begin errors++; $display("FAIL over_enter got %b want %b", outs, vec(0, 1, 2, 1, 0, 0)); end
    repeat (3) cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(0, 0, 2, 1, 0, 0)) begin errors++; $display("FAIL over_stay got %b want %b", outs, vec(0, 0, 2, 1, 0, 0)); end
    cycle(1'b0, 1'b1);
    checks++;
    if (outs !== vec(0, 1, 0, 0, 0, 0)) begin errors++; $display("FAIL over_restart got %b want %b", outs, vec(0, 1, 0, 0, 0, 0)); end
    cycle(1'b0, 1'b0);
    checks++;
    if (outs !== vec(0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL over_single_pulse got %b want %b", outs, vec(0, 0, 0, 0, 0, 0)); end
  endtask

  task automatic test_reset_mid_hold();
    int pulses;
    apply_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (50) cycle(1'b0, 1'b0);
    Reset = 1'b0;
    #1;
    checks++;
    if (outs !== 9'd0) begin errors++; $display("FAIL midhold_async got %b want %b", outs, 9'd0); end
    model_reset();
    pulses = 0;
    repeat (3) begin
      @(posedge frame_clk);
      #1;
      if (round_reset !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midhold_no_pulse got %0d want 0", pulses); end
    Reset = 1'b1;
    cycle(1'b0, 1'b0);
    checks++;
    if (outs !== vec(0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL midhold_idle got %b want %b", outs, vec(0, 0, 0, 0, 0, 0)); end
    cycle(1'b0, 1'b1);
    checks++;
    if (outs !== vec(1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL midhold_restart got %b want %b", outs, vec(1, 0, 0, 0, 0, 0)); end
  endtask

  task automatic test_timeout();
    int bad;
    apply_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (HOLD) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
`ifdef WIN_TRACKER_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < TO - 1; i++) begin
      cycle(1'b0, 1'b0);
      if (outs !== vec(1, 0, 1, 0, 0, 0)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_early got %0d bad cycles want 0", bad); end
    cycle(1'b0, 1'b0);
    checks++;
    if (outs !== vec(0, 1, 1, 0, 0, 1)) begin errors++; $display("FAIL timeout_fire got %b want %b", outs, vec(0, 1, 1, 0, 0, 1)); end
    cycle(1'b0, 1'b0);
    checks++;
    if (outs !== vec(0, 0, 1, 0, 0, 1)) begin errors++; $display("FAIL timeout_sticky got %b want %b", outs, vec(0, 0, 1, 0, 0, 1)); end
    cycle(1'b0, 1'b1);
    checks++;
    if (outs !== vec(1, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL timeout_clear got %b want %b", outs, vec(1, 0, 1, 0, 0, 0)); end
`else
    bad = 0;
    for (int i = 0; i < 3 * TO; i++) begin
      cycle(1'b0, 1'b0);
      if (outs !== vec(1, 0, 1, 0, 0, 0)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL no_timeout got %0d bad cycles want 0", bad); end
`endif
  endtask

  task automatic test_collision();
    apply_reset();
    cycle(1'b0, 1'b1);
    repeat (TO - 2) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(1, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL collide_pre got %b want %b", outs, vec(1, 0, 0, 0, 0, 0)); end
    cycle(1'b1, 1'b0);
    checks++;
    if (outs !== vec(0, 0, 1, 0, 1, 0)) begin errors++; $display("FAIL collide_win got %b want %b", outs, vec(0, 0, 1, 0, 1, 0)); end
  endtask

  task automatic test_random();
    bit w, s;
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      w = ($urandom_range(0, 99) < 60);
      s = ($urandom_range(0, 99) < 6);
      cycle(w, s);
      checks++;
      if (outs !== model_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random_cycle_%0d got %b want %b", i, outs, model_vec());
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_basic_win();
    test_w_held_retrigger();
    test_game_over();
    test_reset_mid_hold();
    test_timeout();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
